writeback_arbiter: RTL and testbench

WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

---
 rtl/writeback_arbiter.sv | 156 +++++++++++++++
 tb/tb_writeback_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: per-channel result FIFOs feeding a single register-file
// write port through a round-robin arbiter with registered write outputs.
//
// Handshake: on channel c a transfer happens at the rising edge where
// I_Valid[c] && O_Ready[c]. O_Ready[c] is combinational (I_LOCK && !full),
// so a full FIFO never accepts, even if it dequeues in that same cycle.
// A transfer whose I_WrEn[c] is low is accepted and dropped without
// occupying a FIFO entry.
module writeback_arbiter #(
  parameter int NUM_CH = 2,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4
) (
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic                     I_Stall,
  input  logic [NUM_CH-1:0]        I_Valid,
  input  logic [NUM_CH-1:0]        I_WrEn,
  input  logic [NUM_CH*IDX_W-1:0]  I_DestRegIdx,
  input  logic [NUM_CH*DATA_W-1:0] I_Data,
  output logic [NUM_CH-1:0]        O_Ready,
  output logic                     O_WriteBackEnable,
  output logic [IDX_W-1:0]         O_WriteBackRegIdx,
  output logic [DATA_W-1:0]        O_WriteBackData,
  output logic                     O_Idle
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Per-channel FIFO storage and bookkeeping
  logic [IDX_W-1:0]  idxMem  [NUM_CH][DEPTH];
  logic [DATA_W-1:0] dataMem [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wrPtr   [NUM_CH];
  logic [PTR_W-1:0]  rdPtr   [NUM_CH];
  logic [CNT_W-1:0]  count   [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] enq;
  logic [NUM_CH-1:0] deqSel;

  // Arbiter state and decisions
  logic [RR_W-1:0] rrPtr;
  logic [RR_W-1:0] rrNext;
  logic [RR_W-1:0] grantCh;
  logic            anyPending;
  logic            doDeq;

  // Full/empty flags, accept strobes and enqueue qualifiers per channel
  always_comb begin
    full    = '0;
    empty   = '0;
    O_Ready = '0;
    enq     = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      full[c]    = (count[c] == CNT_W'(DEPTH));
      empty[c]   = (count[c] == '0);
      O_Ready[c] = I_LOCK && !full[c];
      enq[c]     = I_Valid[c] && O_Ready[c] && I_WrEn[c];
    end
  end

  // Round-robin search over non-empty FIFOs starting at rrPtr; scanning
  // from the far end down lets the closest candidate overwrite the rest.
  always_comb begin
    int ch;
    ch         = 0;
    grantCh    = '0;
    anyPending = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      ch = (int'(rrPtr) + k) % NUM_CH;
      if (!empty[ch]) begin
        grantCh    = RR_W'(ch);
        anyPending = 1'b1;
      end
    end
  end

  // Dequeue decision, per-channel dequeue select and next round-robin start
  always_comb begin
    doDeq  = I_LOCK && !I_Stall && anyPending;
    deqSel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      deqSel[c] = doDeq && (grantCh == RR_W'(c));
    end
    if (int'(grantCh) == NUM_CH - 1) begin
      rrNext = '0;
    end else begin
      rrNext = grantCh + RR_W'(1);
    end
  end

  // FIFO pointers and occupancy; simultaneous enq/deq leaves count unchanged
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wrPtr[c] <= '0;
        rdPtr[c] <= '0;
        count[c] <= '0;
      end
    end else if (I_LOCK) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (enq[c]) begin
          wrPtr[c] <= wrPtr[c] + PTR_W'(1);
        end
        if (deqSel[c]) begin
          rdPtr[c] <= rdPtr[c] + PTR_W'(1);
        end
        case ({enq[c], deqSel[c]})
          2'b10:   count[c] <= count[c] + CNT_W'(1);
          2'b01:   count[c] <= count[c] - CNT_W'(1);
          default: count[c] <= count[c];
        endcase
      end
    end
  end

  // FIFO payload storage; contents are meaningless until pointers cover them
  always_ff @(posedge I_CLOCK) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (enq[c]) begin
        idxMem[c][wrPtr[c]]  <= I_DestRegIdx[c*IDX_W +: IDX_W];
        dataMem[c][wrPtr[c]] <= I_Data[c*DATA_W +: DATA_W];
      end
    end
  end

  // Registered write port and round-robin pointer; frozen when I_LOCK is low
  always_ff @(posedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      rrPtr             <= '0;
      O_WriteBackEnable <= 1'b0;
      O_WriteBackRegIdx <= '0;
      O_WriteBackData   <= '0;
    end else if (I_LOCK) begin
      if (doDeq) begin
        rrPtr             <= rrNext;
        O_WriteBackEnable <= 1'b1;
        O_WriteBackRegIdx <= idxMem[grantCh][rdPtr[grantCh]];
        O_WriteBackData   <= dataMem[grantCh][rdPtr[grantCh]];
      end else begin
        O_WriteBackEnable <= 1'b0;
      end
    end
  end

  // Idle when nothing is buffered and no write is being presented
  always_comb begin
    O_Idle = (&empty) && !O_WriteBackEnable;
  end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (NUM_CH=2, DEPTH=4, DATA_W=16, IDX_W=4).
module tb_writeback_arbiter;

  logic        clk;
  logic        rst;
  logic        lock;
  logic        stall;
  logic [1:0]  valid;
  logic [1:0]  wr_en;
  logic [7:0]  dest_idx;
  logic [31:0] data;
  logic [1:0]  ready;
  logic        wb_en;
  logic [3:0]  wb_idx;
  logic [15:0] wb_data;
  logic        idle;

  int total_cnt;
  int pass_cnt;

  writeback_arbiter #(
    .NUM_CH(2), .DEPTH(4), .DATA_W(16), .IDX_W(4)
  ) dut (
    .I_CLOCK           (clk),
    .I_RESET           (rst),
    .I_LOCK            (lock),
    .I_Stall           (stall),
    .I_Valid           (valid),
    .I_WrEn            (wr_en),
    .I_DestRegIdx      (dest_idx),
    .I_Data            (data),
    .O_Ready           (ready),
    .O_WriteBackEnable (wb_en),
    .O_WriteBackRegIdx (wb_idx),
    .O_WriteBackData   (wb_data),
    .O_Idle            (idle)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_wb(input string tag, input logic en, input logic [3:0] idx, input logic [15:0] dat);
    check({tag, "_en"},   32'(wb_en),   32'(en));
    check({tag, "_idx"},  32'(wb_idx),  32'(idx));
    check({tag, "_data"}, 32'(wb_data), 32'(dat));
  endtask

  task automatic idle_inputs();
    valid    = 2'b00;
    wr_en    = 2'b00;
    dest_idx = 8'h00;
    data     = 32'h0;
  endtask

  initial begin
    total_cnt = 0;
    pass_cnt  = 0;
    rst   = 1'b1;
    lock  = 1'b1;
    stall = 1'b0;
    idle_inputs();

    // reset state
    step();
    step();
    check_wb("reset", 1'b0, 4'h0, 16'h0000);
    check("reset_idle", 32'(idle), 32'd1);
    check("reset_ready", 32'(ready), 32'b11);
    rst = 1'b0;
    step();

    // round-robin: ch0 1/11, 2/22 and ch1 5/55, 6/66 pushed on the same edges
    valid = 2'b11; wr_en = 2'b11;
    dest_idx = {4'd5, 4'd1}; data = {16'h0055, 16'h0011};
    step();
    dest_idx = {4'd6, 4'd2}; data = {16'h0066, 16'h0022};
    step();
    idle_inputs();
    check_wb("rr_w0", 1'b1, 4'd1, 16'h0011);
    step();
    check_wb("rr_w1", 1'b1, 4'd5, 16'h0055);
    step();
    check_wb("rr_w2", 1'b1, 4'd2, 16'h0022);
    step();
    check_wb("rr_w3", 1'b1, 4'd6, 16'h0066);
    step();
    check_wb("rr_done", 1'b0, 4'd6, 16'h0066);
    check("rr_idle", 32'(idle), 32'd1);

    // single entry: one write one cycle after the accepting edge's successor
    valid = 2'b01; wr_en = 2'b01;
    dest_idx = {4'd0, 4'd3}; data = {16'h0000, 16'h00A5};
    step();
    idle_inputs();
    check("single_lat_en", 32'(wb_en), 32'd0);
    check("single_busy", 32'(idle), 32'd0);
    step();
    check_wb("single_w", 1'b1, 4'd3, 16'h00A5);
    step();
    check_wb("single_done", 1'b0, 4'd3, 16'h00A5);
    check("single_idle", 32'(idle), 32'd1);

    // discard: WrEn low is accepted but never buffered or written
    valid = 2'b10; wr_en = 2'b00;
    dest_idx = {4'd7, 4'd0}; data = {16'hBEEF, 16'h0000};
    check("discard_ready", 32'(ready), 32'b11);
    step();
    idle_inputs();
    check("discard_idle", 32'(idle), 32'd1);
    step();
    check("discard_en0", 32'(wb_en), 32'd0);
    step();
    check("discard_en1", 32'(wb_en), 32'd0);
    check("discard_idle2", 32'(idle), 32'd1);

    // full: stall, fill ch0 with 4 entries, 5th offered but refused
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      valid = 2'b01; wr_en = 2'b01;
      dest_idx = {4'd0, 4'(8 + k)}; data = {16'h0000, 16'(16'h0100 + k)};
      step();
    end
    dest_idx = {4'd0, 4'd15}; data = {16'h0000, 16'hDEAD};
    check("full_ready", 32'(ready), 32'b10);
    step();
    idle_inputs();
    check("full_stall_en", 32'(wb_en), 32'd0);
    stall = 1'b0;
    step();
    check_wb("full_w0", 1'b1, 4'd8, 16'h0100);
    step();
    check_wb("full_w1", 1'b1, 4'd9, 16'h0101);
    step();
    check_wb("full_w2", 1'b1, 4'd10, 16'h0102);
    step();
    check_wb("full_w3", 1'b1, 4'd11, 16'h0103);
    step();
    check_wb("full_done", 1'b0, 4'd11, 16'h0103);
    check("full_idle", 32'(idle), 32'd1);

    // freeze: two entries buffered, lock low for 3 cycles
    stall = 1'b1;
    valid = 2'b11; wr_en = 2'b11;
    dest_idx = {4'd9, 4'd4}; data = {16'h0099, 16'h0044};
    step();
    idle_inputs();
    lock  = 1'b0;
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check_wb("freeze", 1'b0, 4'd11, 16'h0103);
      check("freeze_ready", 32'(ready), 32'b00);
    end
    lock = 1'b1;
    step();
    check_wb("thaw_w0", 1'b1, 4'd9, 16'h0099);
    step();
    check_wb("thaw_w1", 1'b1, 4'd4, 16'h0044);
    step();
    check("thaw_done_en", 32'(wb_en), 32'd0);
    check("thaw_idle", 32'(idle), 32'd1);

    // async reset with 3 buffered entries, asserted between edges
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      valid = 2'b01; wr_en = 2'b01;
      dest_idx = {4'd0, 4'(1 + k)}; data = {16'h0000, 16'(16'h00A1 + k)};
      step();
    end
    idle_inputs();
    check("pre_rst_busy", 32'(idle), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_wb("async_rst", 1'b0, 4'd0, 16'h0000);
    check("async_rst_idle", 32'(idle), 32'd1);
    step();
    rst   = 1'b0;
    stall = 1'b0;
    step();
    check("post_rst_en0", 32'(wb_en), 32'd0);
    step();
    check("post_rst_en1", 32'(wb_en), 32'd0);
    check("post_rst_idle", 32'(idle), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
